// File: rtl/fprint_master_arbiter_pkg.sv
// fprint_master_arbiter_pkg
// Shared widths, defaults and state encoding for the fingerprint master
// arbiter.
//   NIOS_ADDRESS_WIDTH / NIOS_DATA_WIDTH : Avalon-MM address and data widths
//   FPRINT_ARB_TIMEOUT_DEFAULT          : default stall-watchdog limit
//   FPRINT_ARB_WD_WIDTH                 : watchdog counter width
//   arb_state_t                         : arbiter FSM states
package fprint_master_arbiter_pkg;

    localparam int NIOS_ADDRESS_WIDTH         = 32;
    localparam int NIOS_DATA_WIDTH            = 32;
    localparam int FPRINT_ARB_TIMEOUT_DEFAULT = 1024;
    localparam int FPRINT_ARB_WD_WIDTH        = 16;

    typedef enum logic {
        FPRINT_ARB_IDLE = 1'b0,
        FPRINT_ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fprint_rr_select.sv
// fprint_rr_select
// Combinational round-robin picker. The search starts at the port after
// 'last' and wraps, so the most recent owner has the lowest priority.
//   req  in  NUM_PORTS : candidate requests
//   last in  IDX_W     : index of the most recent owner
//   gnt  out NUM_PORTS : one-hot winner (0 when no candidate)
//   idx  out IDX_W     : encoded winner index
//   any  out 1         : at least one candidate present
module fprint_rr_select #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);

    localparam logic [IDX_W:0] NP = (IDX_W+1)'(NUM_PORTS);

    // One extra bit on the sum lets last+k exceed NUM_PORTS-1 before the
    // wrap subtraction brings it back into range.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] pos;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        sum = '0;
        pos = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            sum = {1'b0, last} + (IDX_W+1)'(k);
            if (sum >= NP) begin
                sum = sum - NP;
            end
            pos = sum[IDX_W-1:0];
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/fprint_master_arbiter.sv
// fprint_master_arbiter
// Round-robin arbiter sharing one comparator-side Avalon-MM master among
// NUM_PORTS fingerprint store-buffer masters, one transfer at a time.
//   clk, rst (sync, active-low)
//   s_address/s_write/s_read/s_writedata : per-port requests (port i at [i*W +: W])
//   s_waitrequest                        : per-port stall, low only for the owner
//   s_readdata                           : shared read return
//   m_*                                  : forwarded transfer to the comparator
//   grant                                : one-hot owner, 0 when idle
//   proto_err                            : sticky Avalon violation flag
//   timeout                              : sticky stall watchdog flag
module fprint_master_arbiter
    import fprint_master_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int TIMEOUT   = FPRINT_ARB_TIMEOUT_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS*NIOS_ADDRESS_WIDTH-1:0] s_address,
    input  logic [NUM_PORTS-1:0]                s_write,
    input  logic [NUM_PORTS-1:0]                s_read,
    input  logic [NUM_PORTS*NIOS_DATA_WIDTH-1:0] s_writedata,
    output logic [NUM_PORTS-1:0]                s_waitrequest,
    output logic [NIOS_DATA_WIDTH-1:0]          s_readdata,
    output logic [NIOS_ADDRESS_WIDTH-1:0]       m_address,
    output logic                                m_write,
    output logic                                m_read,
    output logic [NIOS_DATA_WIDTH-1:0]          m_writedata,
    input  logic                                m_waitrequest,
    input  logic [NIOS_DATA_WIDTH-1:0]          m_readdata,
    output logic [NUM_PORTS-1:0]                grant,
    output logic                                proto_err,
    output logic                                timeout
);

    localparam int AW  = NIOS_ADDRESS_WIDTH;
    localparam int DW  = NIOS_DATA_WIDTH;
    localparam int IW  = $clog2(NUM_PORTS);
    localparam int WDW = FPRINT_ARB_WD_WIDTH;
    localparam logic [IW-1:0]  LAST_RESET = IW'(NUM_PORTS-1);
    localparam logic [WDW-1:0] WD_LIMIT   = WDW'(TIMEOUT);

    arb_state_t           state, state_nxt;
    logic [NUM_PORTS-1:0] grant_q, grant_nxt;
    logic [IW-1:0]        grant_idx, grant_idx_nxt;
    logic [IW-1:0]        last_q, last_nxt;
    logic [NUM_PORTS-1:0] req, sel_req, sel_gnt;
    logic [IW-1:0]        sel_last, sel_idx;
    logic                 sel_any;
    logic                 busy, owner_write, owner_read, owner_req;
    logic                 complete, violation, dual_cmd;
    logic [WDW-1:0]       wd_q;

    assign req         = s_write | s_read;
    assign busy        = (state == FPRINT_ARB_BUSY);
    assign owner_write = s_write[grant_idx];
    assign owner_read  = s_read[grant_idx];
    assign owner_req   = req[grant_idx];
    assign complete    = busy & owner_req & ~m_waitrequest;
    assign violation   = busy & ~owner_req;
    assign dual_cmd    = busy & owner_write & owner_read;
    assign grant       = grant_q;
    assign s_readdata  = m_readdata;

    // While busy the picker serves the completion re-arbitration: the
    // finishing owner is masked out and the search starts just after it.
    assign sel_req  = busy ? (req & ~grant_q) : req;
    assign sel_last = busy ? grant_idx : last_q;

    fprint_rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IW)
    ) u_rr_select (
        .req  (sel_req),
        .last (sel_last),
        .gnt  (sel_gnt),
        .idx  (sel_idx),
        .any  (sel_any)
    );

    // Next-state logic. A dropped request on the owner abandons the
    // transfer without moving the round-robin pointer.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant_q;
        grant_idx_nxt = grant_idx;
        last_nxt      = last_q;
        case (state)
            FPRINT_ARB_IDLE: begin
                if (sel_any) begin
                    state_nxt     = FPRINT_ARB_BUSY;
                    grant_nxt     = sel_gnt;
                    grant_idx_nxt = sel_idx;
                end
            end
            FPRINT_ARB_BUSY: begin
                if (violation) begin
                    state_nxt = FPRINT_ARB_IDLE;
                    grant_nxt = '0;
                end else if (complete) begin
                    last_nxt = grant_idx;
                    if (sel_any) begin
                        grant_nxt     = sel_gnt;
                        grant_idx_nxt = sel_idx;
                    end else begin
                        state_nxt = FPRINT_ARB_IDLE;
                        grant_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = FPRINT_ARB_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Output mux. A write+read collision is forwarded as a write only.
    always_comb begin
        m_address     = '0;
        m_writedata   = '0;
        m_write       = 1'b0;
        m_read        = 1'b0;
        s_waitrequest = '1;
        if (busy) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant_q[i]) begin
                    m_address   = s_address[i*AW +: AW];
                    m_writedata = s_writedata[i*DW +: DW];
                end
            end
            m_write                  = owner_write;
            m_read                   = owner_read & ~owner_write;
            s_waitrequest[grant_idx] = m_waitrequest;
        end
    end

    // State, pointer, watchdog and sticky flags. The watchdog saturates
    // at the limit; the stalled transfer is left running.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= FPRINT_ARB_IDLE;
            grant_q   <= '0;
            grant_idx <= '0;
            last_q    <= LAST_RESET;
            wd_q      <= '0;
            proto_err <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_q   <= grant_nxt;
            grant_idx <= grant_idx_nxt;
            last_q    <= last_nxt;
            if (violation || dual_cmd) begin
                proto_err <= 1'b1;
            end
            if (!busy || complete) begin
                wd_q <= '0;
            end else if (m_waitrequest && (wd_q != WD_LIMIT)) begin
                wd_q <= wd_q + WDW'(1);
                if (wd_q == WD_LIMIT - WDW'(1)) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule
